// File: rtl/tempo_note_sequencer_pkg.sv
// tempo_note_sequencer_pkg: shared states, widths and constants for the note sequencer
package tempo_note_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, START, PLAY} state_t;
  localparam int NOTE_W = 4;
  localparam int REST_CODE = 0;
  localparam int PERIOD_BASE = 16;
  localparam int TEMPO_W = 3;
  localparam int VOLUME_W = 3;
  localparam int PERIOD_W = $clog2(PERIOD_BASE + 1);
endpackage

// File: rtl/tempo_note_sequencer_input_stabilizer.sv
// input_stabilizer: accepts a raw code only after it has held steady long enough
module input_stabilizer #(
  parameter int WIDTH = 3,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] q
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [WIDTH-1:0] prev;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      prev <= '0;
      cnt <= '0;
      q <= '0;
    end else begin
      prev <= raw;
      if (raw != prev) cnt <= '0;
      else if (cnt == CW'(STABLE_CYCLES - 1)) q <= raw;
      else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/tempo_note_sequencer.sv
// tempo_note_sequencer: issues one pattern note per beat, beat period set by filtered tempo
module tempo_note_sequencer
  import tempo_note_sequencer_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int STEP_W = 3,
  parameter int PERIOD_UNIT = 1562500,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic                          run,
  input  logic [TEMPO_W-1:0]            tempo,
  input  logic [VOLUME_W-1:0]           volume,
  input  logic [NOTE_W*NUM_STEPS-1:0]   pattern,
  input  logic                          note_ready,
  output logic                          note_valid,
  output logic [NOTE_W-1:0]             note_code,
  output logic [VOLUME_W-1:0]           note_volume,
  output logic [STEP_W-1:0]             step,
  output logic                          beat,
  output logic                          overrun
);
  localparam int PRE_W = $clog2(PERIOD_UNIT + 1);
  state_t state, state_n;
  logic [TEMPO_W-1:0] tempo_q;
  logic [VOLUME_W-1:0] volume_q;
  logic [PRE_W-1:0] pre;
  logic [PERIOD_W-1:0] units, period;
  logic unit_end, terminal, load;
  logic [STEP_W-1:0] step_n;
  logic [NOTE_W-1:0] code_n;

  input_stabilizer #(.WIDTH(TEMPO_W), .STABLE_CYCLES(STABLE_CYCLES)) u_tempo (
    .clk(clock_in), .rst(reset), .raw(tempo), .q(tempo_q));
  input_stabilizer #(.WIDTH(VOLUME_W), .STABLE_CYCLES(STABLE_CYCLES)) u_volume (
    .clk(clock_in), .rst(reset), .raw(volume), .q(volume_q));

  assign unit_end = pre == PRE_W'(PERIOD_UNIT - 1);
  assign terminal = unit_end && units == period - 1'b1;

  always_comb begin
    state_n = state;
    if (state != IDLE && !run) state_n = IDLE;
    else if (state == IDLE && run) state_n = START;
    else if (state == START) state_n = PLAY;
    load = run && (state == START || (state == PLAY && terminal));
    step_n = (state == START) ? '0 : step + 1'b1;
    code_n = pattern[NOTE_W*step_n +: NOTE_W];
  end

  always_ff @(posedge clock_in) state <= reset ? IDLE : state_n;

  always_ff @(posedge clock_in)
    if (reset) begin
      pre <= '0;
      units <= '0;
      period <= '0;
      step <= '0;
      note_code <= '0;
      note_volume <= '0;
      note_valid <= 1'b0;
      beat <= 1'b0;
      overrun <= 1'b0;
    end else begin
      beat <= load;
      if (state != PLAY || !run || terminal) begin
        pre <= '0;
        units <= '0;
      end else if (unit_end) begin
        pre <= '0;
        units <= units + 1'b1;
      end else pre <= pre + 1'b1;
      // period is captured per beat so a tempo change never stretches the current beat
      if (load) begin
        period <= PERIOD_W'(PERIOD_BASE - int'(tempo_q));
        step <= step_n;
        note_code <= code_n;
        note_volume <= (code_n == NOTE_W'(REST_CODE)) ? '0 : volume_q;
      end
      note_valid <= (state != IDLE && !run) ? 1'b0 : load ? 1'b1 : note_valid && !note_ready;
      overrun <= (state == START && run) ? 1'b0 : (load && note_valid && !note_ready) ? 1'b1 : overrun;
    end
endmodule

// File: tb/tb_tempo_note_sequencer.sv
// tb_tempo_note_sequencer: directed checks of beat timing, filtering, handshake and reset
module tb_tempo_note_sequencer;
  import tempo_note_sequencer_pkg::*;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, note_ready = 1'b1;
  logic [2:0] tempo = 3'd0, volume = 3'd0;
  logic [31:0] pattern = 32'h87654321;
  logic note_valid, beat, overrun;
  logic [3:0] note_code;
  logic [2:0] note_volume, step;
  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tempo_note_sequencer #(.NUM_STEPS(8), .STEP_W(3), .PERIOD_UNIT(4), .STABLE_CYCLES(3)) dut (
    .clock_in(clk), .reset(reset), .run(run), .tempo(tempo), .volume(volume),
    .pattern(pattern), .note_ready(note_ready), .note_valid(note_valid),
    .note_code(note_code), .note_volume(note_volume), .step(step),
    .beat(beat), .overrun(overrun));

  task automatic wait_beat(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (beat) begin
        at = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL beat_timeout got=none exp=beat within 200 cycles");
  endtask

  task automatic test_reset;
    reset = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (note_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", note_valid); end
    if (note_code !== 4'd0) begin failures++; $display("FAIL rst_code got=%0d exp=0", note_code); end
    if (note_volume !== 3'd0) begin failures++; $display("FAIL rst_volume got=%0d exp=0", note_volume); end
    if (step !== 3'd0) begin failures++; $display("FAIL rst_step got=%0d exp=0", step); end
    if (beat !== 1'b0) begin failures++; $display("FAIL rst_beat got=%0b exp=0", beat); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%0b exp=0", overrun); end
    reset = 1'b0;
  endtask

  task automatic test_beats;
    int prev, t;
    logic [2:0] es;
    tempo = 3'd7;
    volume = 3'd5;
    pattern = 32'h87654321;
    repeat (10) @(negedge clk);
    run = 1'b1;
    wait_beat(prev);
    checks += 4;
    if (step !== 3'd0) begin failures++; $display("FAIL first_step got=%0d exp=0", step); end
    if (note_code !== 4'd1) begin failures++; $display("FAIL first_code got=%0d exp=1", note_code); end
    if (note_volume !== 3'd5) begin failures++; $display("FAIL first_volume got=%0d exp=5", note_volume); end
    if (note_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%0b exp=1", note_valid); end
    @(negedge clk);
    checks += 2;
    if (beat !== 1'b0) begin failures++; $display("FAIL beat_width got=%0b exp=0", beat); end
    if (note_valid !== 1'b0) begin failures++; $display("FAIL valid_after_xfer got=%0b exp=0", note_valid); end
    for (int i = 1; i <= 8; i++) begin
      wait_beat(t);
      es = 3'(i);
      checks += 4;
      if (t - prev !== 36) begin failures++; $display("FAIL interval_t7 step%0d got=%0d exp=36", i, t - prev); end
      if (step !== es) begin failures++; $display("FAIL step_seq got=%0d exp=%0d", step, es); end
      if (note_code !== pattern[4*es +: 4]) begin failures++; $display("FAIL code_seq step%0d got=%0d exp=%0d", es, note_code, pattern[4*es +: 4]); end
      if (note_volume !== 3'd5) begin failures++; $display("FAIL volume_seq got=%0d exp=5", note_volume); end
      prev = t;
    end
  endtask

  task automatic test_tempo_change;
    int b0, b1, b2;
    wait_beat(b0);
    repeat (10) @(negedge clk);
    tempo = 3'd0;
    wait_beat(b1);
    wait_beat(b2);
    checks += 2;
    if (b1 - b0 !== 36) begin failures++; $display("FAIL tempo_current got=%0d exp=36", b1 - b0); end
    if (b2 - b1 !== 64) begin failures++; $display("FAIL tempo_next got=%0d exp=64", b2 - b1); end
  endtask

  task automatic test_filter;
    int b0, t1, t2;
    wait_beat(b0);
    t1 = -1;
    t2 = -1;
    for (int k = 1; k <= 300 && t2 < 0; k++) begin
      @(negedge clk);
      if (k % 2 == 0) tempo = (tempo == 3'd0) ? 3'd7 : 3'd0;
      if (beat) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    tempo = 3'd0;
    checks += 2;
    if (t1 - b0 !== 64) begin failures++; $display("FAIL toggle_gap1 got=%0d exp=64", t1 - b0); end
    if (t2 - t1 !== 64) begin failures++; $display("FAIL toggle_gap2 got=%0d exp=64", t2 - t1); end
  endtask

  task automatic test_overrun;
    int b0, b1, bad;
    logic [3:0] n0;
    logic [2:0] s0, es;
    wait_beat(b0);
    note_ready = 1'b0;
    n0 = note_code;
    s0 = step;
    es = s0 + 3'd1;
    bad = 0;
    b1 = -1;
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%0b exp=0", overrun); end
    for (int i = 0; i < 200 && b1 < 0; i++) begin
      @(negedge clk);
      if (beat) b1 = cyc;
      else if (note_valid !== 1'b1 || note_code !== n0 || step !== s0) bad++;
    end
    checks += 6;
    if (bad !== 0) begin failures++; $display("FAIL hold_stable got=%0d changes exp=0", bad); end
    if (b1 - b0 !== 64) begin failures++; $display("FAIL hold_interval got=%0d exp=64", b1 - b0); end
    if (step !== es) begin failures++; $display("FAIL replace_step got=%0d exp=%0d", step, es); end
    if (note_code !== pattern[4*es +: 4]) begin failures++; $display("FAIL replace_code got=%0d exp=%0d", note_code, pattern[4*es +: 4]); end
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%0b exp=1", overrun); end
    if (note_valid !== 1'b1) begin failures++; $display("FAIL replace_valid got=%0b exp=1", note_valid); end
    note_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (note_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0b exp=0", note_valid); end
    run = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%0b exp=1", overrun); end
    run = 1'b1;
    wait_beat(b0);
    checks += 2;
    if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%0b exp=0", overrun); end
    if (step !== 3'd0) begin failures++; $display("FAIL restart_step got=%0d exp=0", step); end
  endtask

  task automatic test_rest;
    int t;
    run = 1'b0;
    volume = 3'd6;
    pattern = 32'h87654021;
    repeat (10) @(negedge clk);
    checks++;
    if (note_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%0b exp=0", note_valid); end
    run = 1'b1;
    repeat (3) wait_beat(t);
    checks += 3;
    if (step !== 3'd2) begin failures++; $display("FAIL rest_step got=%0d exp=2", step); end
    if (note_code !== 4'd0) begin failures++; $display("FAIL rest_code got=%0d exp=0", note_code); end
    if (note_volume !== 3'd0) begin failures++; $display("FAIL rest_volume got=%0d exp=0", note_volume); end
    wait_beat(t);
    checks += 2;
    if (note_code !== 4'd4) begin failures++; $display("FAIL after_rest_code got=%0d exp=4", note_code); end
    if (note_volume !== 3'd6) begin failures++; $display("FAIL after_rest_volume got=%0d exp=6", note_volume); end
  endtask

  task automatic test_reset_mid;
    int t;
    wait_beat(t);
    note_ready = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (note_valid !== 1'b1) begin failures++; $display("FAIL pending_valid got=%0b exp=1", note_valid); end
    reset = 1'b1;
    @(negedge clk);
    checks += 7;
    if (note_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", note_valid); end
    if (note_code !== 4'd0) begin failures++; $display("FAIL mid_code got=%0d exp=0", note_code); end
    if (note_volume !== 3'd0) begin failures++; $display("FAIL mid_volume got=%0d exp=0", note_volume); end
    if (step !== 3'd0) begin failures++; $display("FAIL mid_step got=%0d exp=0", step); end
    if (beat !== 1'b0) begin failures++; $display("FAIL mid_beat got=%0b exp=0", beat); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL mid_overrun got=%0b exp=0", overrun); end
    if (dut.state !== IDLE) begin failures++; $display("FAIL mid_state got=%0d exp=%0d", dut.state, IDLE); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state !== START) begin failures++; $display("FAIL post_state got=%0d exp=%0d", dut.state, START); end
    @(negedge clk);
    checks += 4;
    if (beat !== 1'b1) begin failures++; $display("FAIL post_beat got=%0b exp=1", beat); end
    if (step !== 3'd0) begin failures++; $display("FAIL post_step got=%0d exp=0", step); end
    if (note_code !== 4'd1) begin failures++; $display("FAIL post_code got=%0d exp=1", note_code); end
    if (note_volume !== 3'd0) begin failures++; $display("FAIL post_volume got=%0d exp=0", note_volume); end
    note_ready = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_beats;
    test_tempo_change;
    test_filter;
    test_overrun;
    test_rest;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
